// File: rtl/imem_loader_if.sv
// Stream-in / memory-write bus between a byte source, the loader and the
// instruction memory write port. The loader takes the slave side; the byte
// source (and whoever observes the write port) takes the master side.
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream program loader: receives LEN_LO, LEN_HI, N payload bytes and a
// mod-256 checksum, writes the payload into the instruction memory starting
// at address 0 and keeps the processor held until the image is verified.
module imem_loader #(
  parameter int MEM_BYTES = 208
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  imem_loader_if.slave        bus,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_error,
  output logic [15:0]         byte_count
);

  localparam logic [15:0] MEM_LEN = 16'(MEM_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } state_t;

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [7:0]  sum;
  logic        in_ready;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;

  logic        xfer;
  logic [15:0] len_full;
  logic [15:0] count_inc;

  assign xfer      = bus.in_valid && in_ready;
  // Full length as it becomes known on the LEN_HI transfer.
  assign len_full  = {bus.in_data, len_lo};
  assign count_inc = byte_count + 16'd1;

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  // Load sequencer; every output is registered so the write port and the
  // hold/status levels change exactly one cycle after the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      len_lo     <= 8'd0;
      len        <= 16'd0;
      sum        <= 8'd0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 64'd0;
      mem_wdata  <= 8'd0;
      byte_count <= 16'd0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      // Write strobe is a single-cycle pulse; address/data simply hold.
      mem_we <= 1'b0;

      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state      <= LEN_LO;
            in_ready   <= 1'b1;
            byte_count <= 16'd0;
            sum        <= 8'd0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            cpu_hold   <= 1'b1;
          end
        end

        LEN_LO: begin
          if (xfer) begin
            len_lo <= bus.in_data;
            state  <= LEN_HI;
          end
        end

        LEN_HI: begin
          if (xfer) begin
            len <= len_full;
            if (len_full > MEM_LEN) begin
              // Image cannot fit: refuse it before touching memory.
              state      <= ERROR;
              in_ready   <= 1'b0;
              load_error <= 1'b1;
            end else if (len_full == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (xfer) begin
            mem_we     <= 1'b1;
            mem_addr   <= {48'd0, byte_count};
            mem_wdata  <= bus.in_data;
            sum        <= sum + bus.in_data;
            byte_count <= count_inc;
            if (count_inc == len) begin
              state <= CSUM;
            end
          end
        end

        CSUM: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (bus.in_data == sum) begin
              // Last payload write was issued during this CSUM cycle, so
              // releasing the processor on this edge is safe.
              state     <= DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a scoreboard queue of expected memory
// writes is filled as payload bytes are accepted and drained by a write
// monitor; status levels are checked at load boundaries.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [15:0] byte_count;

  imem_loader_if bus ();

  imem_loader #(.MEM_BYTES(208)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error),
    .byte_count (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [71:0] exp_q[$];
  logic [63:0] next_addr;
  logic [7:0]  tb_mem [0:207];
  logic [7:0]  img [0:7];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", bus.mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [71:0] e;
        e = exp_q.pop_front();
        check("write_addr", bus.mem_addr, e[71:8]);
        check("write_data", {56'd0, bus.mem_wdata}, {56'd0, e[7:0]});
        $display("write addr=%0d data=%02h", bus.mem_addr, bus.mem_wdata);
      end
      if (bus.mem_addr < 64'd208) tb_mem[bus.mem_addr[7:0]] = bus.mem_wdata;
    end
  end

  // Present one byte and hold it until the loader takes it (bounded).
  task automatic send_byte(input logic [7:0] b, input bit payload);
    int n;
    n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else if (payload) begin
      exp_q.push_back({next_addr, b});
      next_addr++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit fresh);
    if (fresh) next_addr = 64'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic stream(input int n, input logic [7:0] cs, input bit gaps);
    send_byte(n[7:0], 1'b0);
    send_byte(n[15:8], 1'b0);
    if (n <= 208) begin
      for (int i = 0; i < n; i++) begin
        send_byte(img[i], 1'b1);
        if (gaps) begin
          repeat (2) @(posedge clk);
          #1;
        end
      end
      send_byte(cs, 1'b0);
    end
  endtask

  task automatic set_img(input logic [63:0] v);
    for (int i = 0; i < 8; i++) img[i] = v[8*i +: 8];
  endtask

  task automatic check_status(input string tag, input bit done, input bit err,
                              input bit hold, input logic [15:0] cnt);
    check({tag, "_done"},  {63'd0, load_done},  {63'd0, done});
    check({tag, "_error"}, {63'd0, load_error}, {63'd0, err});
    check({tag, "_hold"},  {63'd0, cpu_hold},   {63'd0, hold});
    check({tag, "_count"}, {48'd0, byte_count}, {48'd0, cnt});
    check({tag, "_ready"}, {63'd0, bus.in_ready}, 64'd0);
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    $display("load %s: done=%0d error=%0d hold=%0d count=%0d",
             tag, load_done, load_error, cpu_hold, byte_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 208; i++) tb_mem[i] = 8'h00;
    next_addr    = 64'd0;
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #1;
    // Reset values
    check("rst_ready", {63'd0, bus.in_ready}, 64'd0);
    check("rst_we",    {63'd0, bus.mem_we}, 64'd0);
    check("rst_addr",  bus.mem_addr, 64'd0);
    check("rst_hold",  {63'd0, cpu_hold}, 64'd1);
    check("rst_done",  {63'd0, load_done}, 64'd0);
    check("rst_count", {48'd0, byte_count}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Nominal load
    set_img(64'h0010_0293_0000_0513);
    pulse_start(1'b1);
    check("start_ready", {63'd0, bus.in_ready}, 64'd1);
    stream(8, 8'hBD, 1'b0);
    check_status("nominal", 1'b1, 1'b0, 1'b0, 16'd8);
    for (int i = 0; i < 8; i++) check("nominal_mem", {56'd0, tb_mem[i]}, {56'd0, img[i]});

    // Bad checksum
    pulse_start(1'b1);
    check("restart_hold", {63'd0, cpu_hold}, 64'd1);
    stream(8, 8'hBC, 1'b0);
    check_status("badsum", 1'b0, 1'b1, 1'b1, 16'd8);

    // Length too large: no writes, error right after LEN_HI
    pulse_start(1'b1);
    stream(209, 8'h00, 1'b0);
    check_status("len209", 1'b0, 1'b1, 1'b1, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    check("len209_ready_later", {63'd0, bus.in_ready}, 64'd0);

    // Zero length
    pulse_start(1'b1);
    stream(0, 8'h00, 1'b0);
    check_status("len0", 1'b1, 1'b0, 1'b0, 16'd0);

    // Flow control with valid gaps
    pulse_start(1'b1);
    stream(8, 8'hBD, 1'b1);
    check_status("gaps", 1'b1, 1'b0, 1'b0, 16'd8);

    // start mid-DATA is ignored
    set_img(64'h0000_0000_4433_2211);
    pulse_start(1'b1);
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(img[0], 1'b1);
    send_byte(img[1], 1'b1);
    pulse_start(1'b0);
    send_byte(img[2], 1'b1);
    send_byte(img[3], 1'b1);
    send_byte(8'hAA, 1'b0);
    check_status("ignstart", 1'b1, 1'b0, 1'b0, 16'd4);

    // Reset mid-load after 3 payload bytes
    set_img(64'h0010_0293_0000_0513);
    pulse_start(1'b1);
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(img[i], 1'b1);
    @(posedge clk);
    #1;
    check("mid_count", {48'd0, byte_count}, 64'd3);
    reset = 1'b1;
    #1;
    check("midrst_ready", {63'd0, bus.in_ready}, 64'd0);
    check("midrst_hold",  {63'd0, cpu_hold}, 64'd1);
    check("midrst_count", {48'd0, byte_count}, 64'd0);
    check("midrst_addr",  bus.mem_addr, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("midrst_idle_ready", {63'd0, bus.in_ready}, 64'd0);
    pulse_start(1'b1);
    stream(8, 8'hBD, 1'b0);
    check_status("after_rst", 1'b1, 1'b0, 1'b0, 16'd8);

    // Reload a 4-byte image over the 8-byte one
    set_img(64'h0000_0000_DDCC_BBAA);
    pulse_start(1'b1);
    check("reload_hold", {63'd0, cpu_hold}, 64'd1);
    check("reload_done_low", {63'd0, load_done}, 64'd0);
    stream(4, 8'h0E, 1'b0);
    check_status("reload", 1'b1, 1'b0, 1'b0, 16'd4);
    for (int i = 0; i < 4; i++) check("reload_mem_new", {56'd0, tb_mem[i]}, {56'd0, img[i]});
    set_img(64'h0010_0293_0000_0513);
    for (int i = 4; i < 8; i++) check("reload_mem_old", {56'd0, tb_mem[i]}, {56'd0, img[i]});

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
